clk_divider_prog: RTL and testbench
===================================

Name: clk_divider_prog

Overview:
Runtime-programmable clock-enable/divided-clock generator for fabric-side timing (baud ticks, LED strobes, slow sample clocks).
- Divisor and high time are programmable at run time, so odd ratios and non-50% duty cycles are possible.
- Configuration updates are glitch-free; they take effect only at a period boundary.
- Graceful enable/disable: the current period always completes before stopping.
- Registered divided output plus one-cycle rise/fall tick strobes.

Parameters:
CNT_WIDTH, 16, width of the counter and of the divisor/high-time fields
DIV_DEFAULT, 4, divisor loaded at reset (period in i_clk cycles)
HIGH_DEFAULT, 2, high time loaded at reset (i_clk cycles per period that o_frequency is 1)

Ports:
i_clk  in  1  system clock
i_reset  in  1  reset; synchronous, active-high
i_enable  in  1  run request (level)
i_load  in  1  one-cycle strobe; samples i_div/i_high
i_div  in  CNT_WIDTH  requested divisor, unsigned
i_high  in  CNT_WIDTH  requested high time, unsigned
o_frequency  out  1  divided output, registered
o_tick_rise  out  1  one-cycle pulse in the first high cycle of each period
o_tick_fall  out  1  one-cycle pulse in the first low cycle of each period
o_pending  out  1  a validated config is waiting for the next boundary
o_cfg_err  out  1  one-cycle pulse: rejected load

Behaviour:
- Single clock i_clk; i_reset synchronous active-high.
- Reset (any edge with i_reset=1; overrides all other inputs):
  - state IDLE, cnt=0, div_r=DIV_DEFAULT, high_r=HIGH_DEFAULT, pending cleared.
  - All outputs 0.
- Elaboration check: DIV_DEFAULT ≥ 2, 1 ≤ HIGH_DEFAULT < DIV_DEFAULT, DIV_DEFAULT ≤ 2^CNT_WIDTH−1. Violation is a fatal elaboration error.
- Valid config: div ≥ 2 and 1 ≤ high ≤ div−1. All comparisons are unsigned at CNT_WIDTH.
- States:
  - IDLE: cnt=0, o_frequency=0. Leaves to RUN on the edge where i_enable=1.
  - RUN: cnt cycles 0..div_r−1 and wraps to 0. If i_enable=0 → STOP.
  - STOP: keeps counting. If i_enable=1 → RUN with no disturbance to cnt or output. At the wrap edge (cnt=div_r−1) → IDLE.
- Output rules:
  - o_frequency is registered: it is 1 exactly in the cycles where the registered cnt < high_r while in RUN or STOP.
  - Latency: o_frequency=1, cnt=0 and o_tick_rise=1 all appear in the cycle after the edge at which i_enable is first sampled high in IDLE.
  - o_tick_rise=1 when cnt=0 (RUN/STOP). o_tick_fall=1 when cnt=high_r. Neither asserts in IDLE.
- Period boundary is the wrap edge (cnt=div_r−1 → 0). A boundary edge that moves STOP→IDLE also counts as a boundary.
- Load handling:
  - Valid i_load in RUN/STOP: the values go to the pending registers and o_pending=1 from the next cycle.
  - At the next boundary edge, pending is copied to div_r/high_r and o_pending clears. The new period therefore starts with the new values.
  - Valid i_load in IDLE: div_r/high_r update at that edge; o_pending stays 0.
  - i_load while pending: the last one wins.
  - i_load on a boundary edge: the boundary applies the pending contents as they stood before the edge. The new load becomes pending and applies at the following boundary.
  - Invalid i_load: o_cfg_err=1 for exactly one cycle. Active and pending config are unchanged.
- i_load together with an IDLE→RUN transition: the new config applies, and the first period uses it.
- cnt never exceeds div_r−1. No glitches are possible: every output comes straight from a flop.

Decomposition:
- Package clk_div_pkg holds:
  - state enum typedef (ST_IDLE, ST_RUN, ST_STOP);
  - localparam MIN_DIV = 2.
- Sub-module clk_div_cfg_shadow:
  - validates i_div/i_high;
  - holds the pending registers and o_pending;
  - generates o_cfg_err;
  - presents the apply-at-boundary handshake to the counter/FSM top.

Test Plan:
1. Reset, defaults, i_enable=1 → o_frequency 1,1,0,0 repeating; o_tick_rise every 4th cycle from the first cycle after enable; o_tick_fall on the 3rd.
2. In IDLE load div=5, high=2, then enable → pattern 1,1,0,0,0; o_tick_fall when cnt=2; o_pending stays 0.
3. Running div=4 high=2, load div=6 high=3 at cnt=1 → o_pending=1 for 2 cycles; that period ends 0,0; next periods 1,1,1,0,0,0; o_pending clears at the wrap edge.
4. Loads (div=1, high=1), (div=4, high=0), (div=4, high=4) → each gives a single-cycle o_cfg_err; waveform and o_pending unchanged.
5. Drop i_enable at cnt=0 (div=4) → output 1,1,0,0 then 0 in IDLE, no ticks. Repeat, re-asserting i_enable at cnt=2 → seamless 1,1,0,0,1,1,…
6. Assert i_reset at cnt=1 while high → next cycle all outputs 0, div_r=4, high_r=2. Pending load discarded, and no o_pending after reset.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
// The state encoding is exposed on the top-level debug port, so keep it stable.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_cfg_shadow.sv
// Validates requested divisor/high-time pairs and holds the shadow (pending) copy.
// The shadow copy is handed to the counter at the next period boundary.
module clk_div_cfg_shadow
  import clk_div_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_div,
  input  logic [CNT_WIDTH-1:0] i_high,
  input  logic                 i_idle,
  input  logic                 i_boundary,
  output logic                 o_load_now,
  output logic                 o_apply,
  output logic                 o_pending,
  output logic [CNT_WIDTH-1:0] o_pend_div,
  output logic [CNT_WIDTH-1:0] o_pend_high,
  output logic                 o_cfg_err
);

  localparam logic [CNT_WIDTH-1:0] DIV_MIN = CNT_WIDTH'(MIN_DIV);

  logic cfg_valid;
  logic load_ok;

  // Valid means div >= 2 and 1 <= high <= div-1, all unsigned.
  assign cfg_valid = (i_div >= DIV_MIN) && (i_high != '0) && (i_high < i_div);
  assign load_ok   = i_load && cfg_valid;

  // Handshake to the counter: o_load_now asks it to take i_div/i_high at this
  // edge (only while idle); o_apply asks it to take o_pend_div/o_pend_high at
  // this edge. Both are single-edge qualifiers, no acknowledge is returned.
  assign o_load_now = load_ok && i_idle;
  assign o_apply    = i_boundary && o_pending;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_pending   <= 1'b0;
      o_pend_div  <= '0;
      o_pend_high <= '0;
      o_cfg_err   <= 1'b0;
    end else begin
      o_cfg_err <= i_load && !cfg_valid;
      // A load on a boundary edge replaces the shadow after the old contents
      // have been consumed by o_apply at this same edge.
      if (load_ok && !i_idle) begin
        o_pend_div  <= i_div;
        o_pend_high <= i_high;
        o_pending   <= 1'b1;
      end else if (i_boundary) begin
        o_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_divider_prog.sv
// Runtime-programmable divided clock with rise/fall tick strobes.
// All outputs are flops fed from next-state logic, so they cannot glitch.
module clk_divider_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_WIDTH    = 16,
  parameter int DIV_DEFAULT  = 4,
  parameter int HIGH_DEFAULT = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_div,
  input  logic [CNT_WIDTH-1:0] i_high,
  output logic                 o_frequency,
  output logic                 o_tick_rise,
  output logic                 o_tick_fall,
  output logic                 o_pending,
  output logic                 o_cfg_err,
  output logic [1:0]           o_state
);

  if ((DIV_DEFAULT < MIN_DIV) || (HIGH_DEFAULT < 1) || (HIGH_DEFAULT >= DIV_DEFAULT) ||
      (64'(DIV_DEFAULT) > ((64'd1 << CNT_WIDTH) - 64'd1))) begin : g_bad_defaults
    $fatal(1, "clk_divider_prog: illegal DIV_DEFAULT/HIGH_DEFAULT for CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] DIV_INIT  = CNT_WIDTH'(DIV_DEFAULT);
  localparam logic [CNT_WIDTH-1:0] HIGH_INIT = CNT_WIDTH'(HIGH_DEFAULT);

  state_t               state;
  state_t               state_n;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_n;
  logic [CNT_WIDTH-1:0] div_r;
  logic [CNT_WIDTH-1:0] div_n;
  logic [CNT_WIDTH-1:0] high_r;
  logic [CNT_WIDTH-1:0] high_n;
  logic [CNT_WIDTH-1:0] pend_div;
  logic [CNT_WIDTH-1:0] pend_high;
  logic                 wrap;
  logic                 running_n;
  logic                 load_now;
  logic                 apply;

  // The wrap edge is the period boundary; it can only occur in RUN or STOP.
  assign wrap = (state != ST_IDLE) && (cnt == (div_r - CNT_ONE));

  clk_div_cfg_shadow #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cfg_shadow (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (i_load),
    .i_div       (i_div),
    .i_high      (i_high),
    .i_idle      (state == ST_IDLE),
    .i_boundary  (wrap),
    .o_load_now  (load_now),
    .o_apply     (apply),
    .o_pending   (o_pending),
    .o_pend_div  (pend_div),
    .o_pend_high (pend_high),
    .o_cfg_err   (o_cfg_err)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_n   = div_r;
    high_n  = high_r;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (i_enable) state_n = ST_RUN;
      end
      ST_RUN: begin
        cnt_n = wrap ? '0 : cnt + CNT_ONE;
        if (!i_enable) state_n = ST_STOP;
      end
      ST_STOP: begin
        cnt_n = wrap ? '0 : cnt + CNT_ONE;
        if (i_enable) state_n = ST_RUN;
        else if (wrap) state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
    if (load_now) begin
      div_n  = i_div;
      high_n = i_high;
    end else if (apply) begin
      div_n  = pend_div;
      high_n = pend_high;
    end
  end

  assign running_n = (state_n != ST_IDLE);

  // Outputs are computed from the next count and next config, so the first
  // cycle of a period already reflects a config applied at its boundary.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      div_r       <= DIV_INIT;
      high_r      <= HIGH_INIT;
      o_frequency <= 1'b0;
      o_tick_rise <= 1'b0;
      o_tick_fall <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      div_r       <= div_n;
      high_r      <= high_n;
      o_frequency <= running_n && (cnt_n < high_n);
      o_tick_rise <= running_n && (cnt_n == '0);
      o_tick_fall <= running_n && (cnt_n == high_n);
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed bench for clk_divider_prog: per-cycle expected output vectors
// {frequency, tick_rise, tick_fall, pending, cfg_err} queued and compared.
module tb_clk_divider_prog;
  import clk_div_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] div = '0;
  logic [W-1:0] high = '0;
  logic         frequency;
  logic         tick_rise;
  logic         tick_fall;
  logic         pending;
  logic         cfg_err;
  logic [1:0]   state;

  logic [4:0]   exp_q[$];
  string        tag_q[$];
  int           tests_run = 0;
  int           fails = 0;

  // clock / reset
  always #5 clk = ~clk;

  clk_divider_prog #(
    .CNT_WIDTH    (W),
    .DIV_DEFAULT  (4),
    .HIGH_DEFAULT (2)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_enable    (enable),
    .i_load      (load),
    .i_div       (div),
    .i_high      (high),
    .o_frequency (frequency),
    .o_tick_rise (tick_rise),
    .o_tick_fall (tick_fall),
    .o_pending   (pending),
    .o_cfg_err   (cfg_err),
    .o_state     (state)
  );

  // scoreboard
  task automatic check_outputs();
    logic [4:0] exp;
    logic [4:0] obs;
    string      tag;
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    obs = {frequency, tick_rise, tick_fall, pending, cfg_err};
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed f/r/fl/p/e=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_state(input logic [1:0] exp, input string tag);
    tests_run++;
    assert (state === exp) else begin
      fails++;
      $error("FAIL %s: observed state=%0d expected %0d", tag, state, exp);
    end
  endtask

  // driver: apply inputs for one edge, queue the expected result, sample after it
  task automatic cyc(input logic rst, input logic en, input logic ld, input int d,
                     input int h, input logic [4:0] exp, input string tag);
    @(negedge clk);
    reset  = rst;
    enable = en;
    load   = ld;
    div    = W'(d);
    high   = W'(h);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    // 1: reset then default div=4/high=2
    cyc(1, 0, 0, 0, 0, 5'b00000, "reset0");
    cyc(1, 0, 0, 0, 0, 5'b00000, "reset1");
    check_state(2'(ST_IDLE), "reset_state");
    cyc(0, 1, 0, 0, 0, 5'b11000, "def_c0");
    cyc(0, 1, 0, 0, 0, 5'b10000, "def_c1");
    cyc(0, 1, 0, 0, 0, 5'b00100, "def_c2");
    cyc(0, 1, 0, 0, 0, 5'b00000, "def_c3");
    cyc(0, 1, 0, 0, 0, 5'b11000, "def_c0b");
    cyc(0, 1, 0, 0, 0, 5'b10000, "def_c1b");
    cyc(0, 1, 0, 0, 0, 5'b00100, "def_c2b");
    cyc(0, 1, 0, 0, 0, 5'b00000, "def_c3b");

    // 3: load div=6 high=3 at cnt=1, applies at the wrap
    cyc(0, 1, 0, 0, 0, 5'b11000, "t3_c0");
    cyc(0, 1, 0, 0, 0, 5'b10000, "t3_c1");
    cyc(0, 1, 1, 6, 3, 5'b00110, "t3_pend_c2");
    cyc(0, 1, 0, 0, 0, 5'b00010, "t3_pend_c3");
    cyc(0, 1, 0, 0, 0, 5'b11000, "t3_new_c0");
    cyc(0, 1, 0, 0, 0, 5'b10000, "t3_new_c1");
    cyc(0, 1, 0, 0, 0, 5'b10000, "t3_new_c2");
    cyc(0, 1, 0, 0, 0, 5'b00100, "t3_new_c3");
    cyc(0, 1, 0, 0, 0, 5'b00000, "t3_new_c4");
    cyc(0, 1, 0, 0, 0, 5'b00000, "t3_new_c5");
    cyc(0, 1, 0, 0, 0, 5'b11000, "t3_new_c0b");

    // 4: invalid loads leave everything unchanged
    cyc(0, 1, 1, 1, 1, 5'b10001, "t4_div1");
    cyc(0, 1, 1, 4, 0, 5'b10001, "t4_high0");
    cyc(0, 1, 1, 4, 4, 5'b00101, "t4_high_eq_div");
    cyc(0, 1, 0, 0, 0, 5'b00000, "t4_c4");
    cyc(0, 1, 0, 0, 0, 5'b00000, "t4_c5");
    cyc(0, 1, 0, 0, 0, 5'b11000, "t4_c0");

    // back to div=4 high=2, then 5: graceful stop
    cyc(0, 1, 1, 4, 2, 5'b10010, "t5_ld_c1");
    cyc(0, 1, 0, 0, 0, 5'b10010, "t5_ld_c2");
    cyc(0, 1, 0, 0, 0, 5'b00110, "t5_ld_c3");
    cyc(0, 1, 0, 0, 0, 5'b00010, "t5_ld_c4");
    cyc(0, 1, 0, 0, 0, 5'b00010, "t5_ld_c5");
    cyc(0, 1, 0, 0, 0, 5'b11000, "t5_ld_c0");
    cyc(0, 0, 0, 0, 0, 5'b10000, "t5_stop_c1");
    check_state(2'(ST_STOP), "t5_stop_state");
    cyc(0, 0, 0, 0, 0, 5'b00100, "t5_stop_c2");
    cyc(0, 0, 0, 0, 0, 5'b00000, "t5_stop_c3");
    cyc(0, 0, 0, 0, 0, 5'b00000, "t5_idle0");
    check_state(2'(ST_IDLE), "t5_idle_state");
    cyc(0, 0, 0, 0, 0, 5'b00000, "t5_idle1");
    cyc(0, 1, 0, 0, 0, 5'b11000, "t5_re_c0");
    cyc(0, 0, 0, 0, 0, 5'b10000, "t5_re_c1");
    cyc(0, 0, 0, 0, 0, 5'b00100, "t5_re_c2");
    cyc(0, 1, 0, 0, 0, 5'b00000, "t5_resume_c3");
    cyc(0, 1, 0, 0, 0, 5'b11000, "t5_resume_c0");
    cyc(0, 1, 0, 0, 0, 5'b10000, "t5_resume_c1");

    // 2: idle load div=5 high=2 applies immediately, never pending
    cyc(0, 0, 0, 0, 0, 5'b00100, "t2_stop_c2");
    cyc(0, 0, 0, 0, 0, 5'b00000, "t2_stop_c3");
    cyc(0, 0, 0, 0, 0, 5'b00000, "t2_idle");
    cyc(0, 0, 1, 5, 2, 5'b00000, "t2_idle_load");
    cyc(0, 1, 0, 0, 0, 5'b11000, "t2_c0");
    cyc(0, 1, 0, 0, 0, 5'b10000, "t2_c1");
    cyc(0, 1, 0, 0, 0, 5'b00100, "t2_c2");
    cyc(0, 1, 0, 0, 0, 5'b00000, "t2_c3");
    cyc(0, 1, 0, 0, 0, 5'b00000, "t2_c4");
    cyc(0, 1, 0, 0, 0, 5'b11000, "t2_c0b");

    // load on a boundary edge: old pending applies, new one waits a period
    cyc(0, 1, 1, 3, 1, 5'b10010, "bd_a_c1");
    cyc(0, 1, 0, 0, 0, 5'b00110, "bd_a_c2");
    cyc(0, 1, 0, 0, 0, 5'b00010, "bd_a_c3");
    cyc(0, 1, 0, 0, 0, 5'b00010, "bd_a_c4");
    cyc(0, 1, 1, 2, 1, 5'b11010, "bd_b_on_wrap");
    cyc(0, 1, 0, 0, 0, 5'b00110, "bd_div3_c1");
    cyc(0, 1, 0, 0, 0, 5'b00010, "bd_div3_c2");
    cyc(0, 1, 0, 0, 0, 5'b11000, "bd_div2_c0");
    cyc(0, 1, 0, 0, 0, 5'b00100, "bd_div2_c1");
    cyc(0, 1, 0, 0, 0, 5'b11000, "bd_div2_c0b");

    // 6: reset mid-period with a pending load
    cyc(0, 1, 1, 4, 2, 5'b00110, "t6_ld_c1");
    cyc(0, 1, 0, 0, 0, 5'b11000, "t6_div4_c0");
    cyc(0, 1, 1, 6, 3, 5'b10010, "t6_pend_c1");
    cyc(1, 1, 0, 0, 0, 5'b00000, "t6_reset");
    check_state(2'(ST_IDLE), "t6_reset_state");
    cyc(0, 0, 0, 0, 0, 5'b00000, "t6_idle");
    cyc(0, 1, 0, 0, 0, 5'b11000, "t6_def_c0");
    cyc(0, 1, 0, 0, 0, 5'b10000, "t6_def_c1");
    cyc(0, 1, 0, 0, 0, 5'b00100, "t6_def_c2");
    cyc(0, 1, 0, 0, 0, 5'b00000, "t6_def_c3");
    cyc(0, 1, 0, 0, 0, 5'b11000, "t6_def_c0b");

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
